// File: rtl/dmem_responder.sv
// Word-organised data-memory responder: zero-wait reads, self-clearing after reset,
// registered debug read port, saturating access counters and sticky address-error flags.
module dmem_responder #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_m_sel,
  input  logic              i_m_rnw,
  input  logic [31:0]       i_m_addr,
  input  logic [31:0]       i_m_data,
  output logic [31:0]       o_s_data,
  input  logic [31:0]       i_dbg_addr,
  output logic [31:0]       o_dbg_data,
  output logic              o_init_busy,
  output logic              o_err_range,
  output logic              o_err_align,
  input  logic              i_err_clr,
  output logic [CNT_W-1:0]  o_rd_count,
  output logic [CNT_W-1:0]  o_wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_ptr;
  logic [31:0]        r_mem [DEPTH];
  logic [31:0]        r_dbg_data;
  logic               r_init_busy;
  logic               r_err_range;
  logic               r_err_align;
  logic [CNT_W-1:0]   r_rd_count;
  logic [CNT_W-1:0]   r_wr_count;

  logic [ADDR_W-1:0]  w_idx;
  logic [ADDR_W-1:0]  w_dbg_idx;
  logic               w_in_range;
  logic               w_aligned;
  logic               w_ready;
  logic               w_valid;
  logic               w_rd;
  logic               w_wr;
  logic               w_dbg_unused;

  assign w_idx        = i_m_addr[ADDR_W+1:2];
  assign w_dbg_idx    = i_dbg_addr[ADDR_W+1:2];
  assign w_in_range   = (i_m_addr[31:ADDR_W+2] == {(30-ADDR_W){1'b0}});
  assign w_aligned    = (i_m_addr[1:0] == 2'b00);
  assign w_ready      = (r_state == ST_READY);
  assign w_valid      = i_m_sel & w_in_range & w_aligned & w_ready;
  assign w_rd         = w_valid & i_m_rnw;
  assign w_wr         = w_valid & ~i_m_rnw;
  assign w_dbg_unused = &{i_dbg_addr[31:ADDR_W+2], i_dbg_addr[1:0]};

  // Same-cycle read data; anything other than a valid read returns zero.
  always_comb begin
    o_s_data = 32'h0000_0000;
    if (w_rd) begin
      o_s_data = r_mem[w_idx];
    end else begin
      o_s_data = 32'h0000_0000;
    end
  end

  // Storage array: the clear sweep owns the write port until the FSM reaches READY.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_ptr] <= 32'h0000_0000;
      end else if (w_wr) begin
        r_mem[w_idx] <= i_m_data;
      end
    end
  end

  // Clear FSM plus every registered status output.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_CLEAR;
      r_ptr       <= {ADDR_W{1'b0}};
      r_init_busy <= 1'b1;
      r_err_range <= 1'b0;
      r_err_align <= 1'b0;
      r_rd_count  <= {CNT_W{1'b0}};
      r_wr_count  <= {CNT_W{1'b0}};
      r_dbg_data  <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_ptr <= r_ptr + PTR_ONE;
          if (r_ptr == PTR_LAST) begin
            r_state     <= ST_READY;
            r_init_busy <= 1'b0;
          end
        end
        ST_READY: begin
          // Sampled before this edge's bus write lands, so a colliding write shows next cycle.
          r_dbg_data <= r_mem[w_dbg_idx];
          if (i_m_sel) begin
            r_err_range <= ~w_in_range | (r_err_range & ~i_err_clr);
            r_err_align <= ~w_aligned  | (r_err_align & ~i_err_clr);
          end
          if (w_rd && (r_rd_count != CNT_MAX)) begin
            r_rd_count <= r_rd_count + CNT_ONE;
          end
          if (w_wr && (r_wr_count != CNT_MAX)) begin
            r_wr_count <= r_wr_count + CNT_ONE;
          end
        end
        default: begin
          r_state     <= ST_CLEAR;
          r_ptr       <= {ADDR_W{1'b0}};
          r_init_busy <= 1'b1;
        end
      endcase
    end
  end

  assign o_dbg_data  = r_dbg_data;
  assign o_init_busy = r_init_busy;
  assign o_err_range = r_err_range;
  assign o_err_align = r_err_align;
  assign o_rd_count  = r_rd_count;
  assign o_wr_count  = r_wr_count;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the core's data-memory bus (m_sel, m_rnw, m_addr, m_data → s_data).
- Word-organised RAM with zero-wait read data.
- Clears itself to zero after reset using a sequential clear FSM.
- Provides a registered debug read port, saturating access counters and sticky error flags for bad addresses.

Parameters:
- ADDR_W, 8: word-index width; DEPTH = 2**ADDR_W words.
- CNT_W, 16: width of the access counters.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- m_sel  in  1  bus access request this cycle
- m_rnw  in  1  1 = read, 0 = write (valid when m_sel=1)
- m_addr  in  32  byte address
- m_data  in  32  write data
- s_data  out  32  read data, same-cycle (combinational from array)
- dbg_addr  in  32  debug byte address
- dbg_data  out  32  registered debug read data
- init_busy  out  1  1 while clear FSM is running
- err_range  out  1  sticky: access beyond DEPTH words
- err_align  out  1  sticky: access with m_addr[1:0] != 0
- err_clr  in  1  clears both error flags
- rd_count  out  CNT_W  successful reads, saturating
- wr_count  out  CNT_W  successful writes, saturating

Behaviour:
- Index and validity:
  - idx = m_addr[ADDR_W+1:2].
  - in_range = (m_addr[31:ADDR_W+2] == 0).
  - aligned = (m_addr[1:0] == 0).
  - valid access = m_sel & in_range & aligned & state==READY.
- FSM has two states, CLEAR and READY.
  - rst_n=0 at an edge → state CLEAR, clear pointer = 0.
  - In CLEAR: write 0 to mem[ptr] each cycle, ptr+1. When ptr == DEPTH-1 is written, the next state is READY.
  - CLEAR therefore lasts exactly DEPTH cycles after rst_n rises.
  - Reset asserted mid-CLEAR or mid-READY restarts CLEAR from ptr 0. Memory contents are not otherwise preserved.
- Reset values (registered at the edge with rst_n=0):
  - init_busy=1, err_range=0, err_align=0, rd_count=0, wr_count=0, dbg_data=0.
- init_busy = (state==CLEAR).
- During CLEAR:
  - Bus accesses are ignored: no write, s_data=0.
  - Counters and error flags do not change.
  - dbg_data stays 0.
- Reads:
  - s_data = mem[idx] when valid & m_rnw; otherwise s_data = 0.
  - No latency and no stall; the core samples s_data in the same cycle.
- Writes:
  - valid & !m_rnw → mem[idx] <= m_data at the edge.
  - A read of the same idx in the next cycle returns the new value.
- Debug port:
  - In READY, dbg_data <= mem[dbg_addr[ADDR_W+1:2]] every cycle. Upper address bits and dbg_addr[1:0] are ignored.
  - Read-before-write: if a bus write hits the same index in the same cycle, dbg_data gets the old value. The new value appears one cycle later.
- Errors (READY only, m_sel=1):
  - !in_range → err_range <= 1.
  - !aligned → err_align <= 1.
  - Both may set in one cycle.
  - An errored access writes nothing, returns s_data=0 and is not counted.
  - err_clr=1 clears both flags. If a new error occurs in the same cycle, set wins.
- Counters:
  - rd_count increments on each valid read; wr_count on each valid write.
  - Each saturates at 2**CNT_W-1 and never wraps.
- m_sel=0: no state change except the clear FSM and the debug register; m_rnw, m_addr and m_data are don't-care.

Test Plan:
- Reset then release:
  - init_busy=1 for exactly 256 cycles, then 0.
  - Read at m_addr=0x3FC returns 0x00000000.
  - Write attempted at 0x10 during CLEAR is ignored (later read returns 0).
- Write then read:
  - Write 0xDEADBEEF to 0x40; next cycle read 0x40 → s_data=0xDEADBEEF same cycle.
  - wr_count=1, rd_count=1.
- Error flags:
  - Read at 0x400 → s_data=0, err_range=1.
  - Write at 0x42 → no change at 0x40, err_align=1.
  - Pulse err_clr together with a new read at 0x500 → err_range stays 1 and err_align becomes 0.
- Debug read-before-write:
  - dbg_addr=0x80 while writing 0x12345678 to 0x80 → dbg_data shows old value, then 0x12345678 next cycle.
- Counter saturation:
  - CNT_W=4: 20 valid reads → rd_count=15 and holds.
- Reset mid-operation:
  - Write 0xA5A5A5A5 to 0x8, assert rst_n=0 for 1 cycle → CLEAR restarts, counters and errors = 0.
  - After 256 cycles, read 0x8 → 0.
